// File: rtl/fetch_pkg.sv
// Shared types for the IF-stage fetch unit: FSM states, queue entry layout and the bubble word.
package fetch_pkg;

   typedef enum logic [1:0] {BOOT, FETCH, FULL, DISCARD} fetch_state_e;

   localparam logic [31:0] BUBBLE_INSTR = 32'h0;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small circular queue of fetched {pc, instr} entries; head is read straight from registered storage.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2,
   localparam int PTR_W = $clog2(DEPTH)
)(
   input  logic         clk,
   input  logic         reset,
   input  logic         clear_i,
   input  logic         push_i,
   input  logic         pop_i,
   input  fetch_entry_t data_i,
   output fetch_entry_t head_o,
   output logic [PTR_W:0] count_o,
   output logic         full_o,
   output logic         empty_o
);

   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   fetch_entry_t     mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             do_push, do_pop;

   assign full_o  = (count_q == FULL_CNT);
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

   // A push into a full queue is only allowed when the head leaves in the same cycle.
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clear_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !clear_i) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/if_fetch_unit.sv
// IF-stage producer: owns the fetch PC, talks to instruction memory, queues returned words and
// presents the queue head to IF/ID, with branch/CSR redirect and in-flight read discard.
module if_fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int          QUEUE_DEPTH = 2
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        csr_redirect,
   input  logic [31:0] csr_pc,
   input  logic        IFID_write,
   input  logic        dm_stall,
   input  logic        im_stall,
   input  logic [31:0] im_rdata,
   output logic        im_req,
   output logic [31:0] im_addr,
   output logic [31:0] instruction,
   output logic [31:0] pc,
   output logic        if_valid,
   output logic        IFID_flush
);

   localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;

   fetch_state_e state_q, state_d;
   logic [31:0]  fetch_pc_q, fetch_pc_d;
   logic [31:0]  hold_addr_q, hold_addr_d;
   logic [31:0]  target;
   logic         redirect_any, accept, push, pop;
   logic [CNT_W-1:0] q_count;
   logic         q_full, q_empty;
   fetch_entry_t q_head, q_wdata;

   assign redirect_any = csr_redirect | redirect_valid;
   assign target       = word_align(csr_redirect ? csr_pc : redirect_pc);
   assign accept       = (state_q == FETCH) & ~im_stall & ~redirect_any;
   assign push         = accept & (~q_full | pop);
   assign pop          = if_valid & IFID_write & ~im_stall & ~dm_stall;
   assign q_wdata      = {fetch_pc_q, im_rdata};

   fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
      .clk     (clk),
      .reset   (reset),
      .clear_i (redirect_any),
      .push_i  (push),
      .pop_i   (pop),
      .data_i  (q_wdata),
      .head_o  (q_head),
      .count_o (q_count),
      .full_o  (q_full),
      .empty_o (q_empty)
   );

   assign if_valid    = ~q_empty;
   assign instruction = q_empty ? BUBBLE_INSTR : q_head.instr;
   assign pc          = q_empty ? 32'h0 : q_head.pc;
   assign IFID_flush  = redirect_any & reset;

   always_comb begin
      state_d     = state_q;
      fetch_pc_d  = fetch_pc_q;
      hold_addr_d = hold_addr_q;
      im_req      = 1'b0;
      im_addr     = fetch_pc_q;
      case (state_q)
         BOOT: state_d = FETCH;
         FETCH: begin
            im_req = 1'b1;
            if (accept) begin
               fetch_pc_d = fetch_pc_q + 32'd4;
               if (!pop && q_count == CNT_W'(QUEUE_DEPTH - 1)) state_d = FULL;
            end
         end
         FULL: if (pop) state_d = FETCH;
         DISCARD: begin
            // The stalled read must stay on the bus unchanged until memory completes it.
            im_req  = 1'b1;
            im_addr = hold_addr_q;
            if (!im_stall) state_d = FETCH;
         end
         default: state_d = BOOT;
      endcase
      if (redirect_any) begin
         fetch_pc_d = target;
         if (state_q == FETCH && im_stall) begin
            state_d     = DISCARD;
            hold_addr_d = fetch_pc_q;
         end else if (state_q == DISCARD && im_stall) begin
            state_d = DISCARD;
         end else begin
            state_d = FETCH;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= BOOT;
         fetch_pc_q  <= RESET_PC;
         hold_addr_q <= '0;
      end else begin
         state_q     <= state_d;
         fetch_pc_q  <= fetch_pc_d;
         hold_addr_q <= hold_addr_d;
      end
   end

endmodule
